// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared encodings, FSM states and frame constants for the SD CMD PHY (GAP state only with CMD_NCC_GAP_EN)
package sd_cmd_pkg;
  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_136  = 2'b01,
    RESP_48   = 2'b10,
    RESP_48B  = 2'b11
  } resp_t;
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    RECV,
    FINISH
`ifdef CMD_NCC_GAP_EN
    , GAP
`endif
  } state_t;
  typedef struct packed {
    logic timeout;
    logic crc;
    logic end_bit;
    logic index;
  } err_t;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int FRAME_48  = 48;
  localparam int FRAME_136 = 136;
endpackage

// File: rtl/sd_cmd_phy_if.sv
// sd_cmd_phy_if: sequencer-side command request and result bundle
interface sd_cmd_phy_if;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         crc_check_en;
  logic         index_check_en;
  logic         busy;
  logic         done;
  logic [127:0] response;
  logic         timeout_err;
  logic         crc_err;
  logic         end_bit_err;
  logic         index_err;
  modport master (
    output start, cmd_index, cmd_argument, resp_type, crc_check_en, index_check_en,
    input  busy, done, response, timeout_err, crc_err, end_bit_err, index_err
  );
  modport slave (
    input  start, cmd_index, cmd_argument, resp_type, crc_check_en, index_check_en,
    output busy, done, response, timeout_err, crc_err, end_bit_err, index_err
  );
endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1, zero seed) with synchronous clear
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [6:0] crc
);
  logic [6:0] crc_d, crc_q;
  // clear wins over shift; feedback is incoming bit xor current MSB
  always_comb crc_d = clr ? 7'h00 : en ? ({crc_q[5:0], 1'b0} ^ ({7{d ^ crc_q[6]}} & CRC7_POLY)) : crc_q;
  // CRC register
  always_ff @(posedge clock) crc_q <= !reset ? 7'h00 : crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD line serialiser/receiver with response checks (CMD_NCC_GAP_EN adds a post-transaction idle gap)
module sd_cmd_phy
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64,
  parameter int NCC_TICKS     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sd_clk_en,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_pin_oe,
  sd_cmd_phy_if.slave  bus
);
  localparam int CMAX0 = TIMEOUT_TICKS > NCC_TICKS ? TIMEOUT_TICKS : NCC_TICKS;
  localparam int CMAX  = CMAX0 > FRAME_136 ? CMAX0 : FRAME_136;
  localparam int CW    = $clog2(CMAX + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t TOUT        = cnt_t'(TIMEOUT_TICKS);
  localparam cnt_t TX_CRC      = cnt_t'(FRAME_48 - 8);
  localparam cnt_t TX_CRC_TOP  = cnt_t'(FRAME_48 - 2);
  localparam cnt_t LAST48      = cnt_t'(FRAME_48 - 1);
  localparam cnt_t LAST136     = cnt_t'(FRAME_136 - 1);
  localparam cnt_t LONG_SKIP   = cnt_t'(8);
  localparam cnt_t LONG_CRC_END = cnt_t'(FRAME_136 - 8);
`ifdef CMD_NCC_GAP_EN
  localparam cnt_t NCC = cnt_t'(NCC_TICKS);
`endif
  state_t         state_d, state_q;
  cnt_t           cnt_d, cnt_q;
  logic [39:0]    tx_d, tx_q;
  logic [126:0]   rx_d, rx_q;
  logic [5:0]     index_d, index_q;
  resp_t          resp_d, resp_q;
  logic           crc_en_d, crc_en_q, idx_en_d, idx_en_q;
  logic           pin_out_d, pin_out_q, pin_oe_d, pin_oe_q;
  logic [127:0]   response_d, response_q;
  err_t           err_d, err_q;
  logic           accept, tx_crc_en, rx_crc_en, long_resp;
  logic [6:0]     tx_crc, rx_crc;
  sd_crc7 u_tx_crc (.clock(clock), .reset(reset), .clr(accept), .en(tx_crc_en), .d(tx_q[39]), .crc(tx_crc));
  sd_crc7 u_rx_crc (.clock(clock), .reset(reset), .clr(accept), .en(rx_crc_en), .d(cmd_pin_in), .crc(rx_crc));
  assign long_resp = resp_q == RESP_136;
  // next-state, pin drive, receive shifting and end-of-frame checks
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    index_d    = index_q;
    resp_d     = resp_q;
    crc_en_d   = crc_en_q;
    idx_en_d   = idx_en_q;
    response_d = response_q;
    err_d      = err_q;
    pin_out_d  = sd_clk_en ? 1'b1 : pin_out_q;
    pin_oe_d   = sd_clk_en ? 1'b0 : pin_oe_q;
    accept     = 1'b0;
    tx_crc_en  = 1'b0;
    rx_crc_en  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        accept     = 1'b1;
        state_d    = SEND;
        cnt_d      = '0;
        tx_d       = {2'b01, bus.cmd_index, bus.cmd_argument};
        rx_d       = '0;
        index_d    = bus.cmd_index;
        resp_d     = resp_t'(bus.resp_type);
        crc_en_d   = bus.crc_check_en;
        idx_en_d   = bus.index_check_en;
        response_d = '0;
        err_d      = '0;
      end
      SEND: if (sd_clk_en) begin
        pin_oe_d  = 1'b1;
        pin_out_d = cnt_q < TX_CRC ? tx_q[39] : cnt_q < LAST48 ? tx_crc[3'(TX_CRC_TOP - cnt_q)] : 1'b1;
        tx_crc_en = cnt_q < TX_CRC;
        tx_d      = {tx_q[38:0], 1'b0};
        cnt_d     = cnt_q + cnt_t'(1);
        if (cnt_q == LAST48) begin
          cnt_d   = '0;
          state_d = resp_q == RESP_NONE ? FINISH : WAIT_RESP;
        end
      end
      WAIT_RESP: if (sd_clk_en) begin
        if (!cmd_pin_in) begin
          state_d   = RECV;
          cnt_d     = cnt_t'(1);
          rx_d      = {rx_q[125:0], cmd_pin_in};
          rx_crc_en = !long_resp;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_d == TOUT) begin
            err_d.timeout = 1'b1;
            state_d       = FINISH;
          end
        end
      end
      RECV: if (sd_clk_en) begin
        rx_d      = {rx_q[125:0], cmd_pin_in};
        cnt_d     = cnt_q + cnt_t'(1);
        rx_crc_en = long_resp ? (cnt_q >= LONG_SKIP && cnt_q < LONG_CRC_END) : cnt_q < TX_CRC;
        if (cnt_q == (long_resp ? LAST136 : LAST48)) begin
          state_d       = FINISH;
          err_d.end_bit = !cmd_pin_in;
          err_d.crc     = crc_en_q && rx_crc != rx_q[6:0];
          err_d.index   = idx_en_q && !long_resp && rx_q[44:39] != index_q;
          response_d    = long_resp ? {8'h00, rx_q[126:7]} : {96'h0, rx_q[38:7]};
        end
      end
`ifdef CMD_NCC_GAP_EN
      FINISH: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (sd_clk_en) begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_d == NCC) state_d = IDLE;
      end
`else
      FINISH: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clock)
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      index_q    <= '0;
      resp_q     <= RESP_NONE;
      crc_en_q   <= 1'b0;
      idx_en_q   <= 1'b0;
      pin_out_q  <= 1'b1;
      pin_oe_q   <= 1'b0;
      response_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      index_q    <= index_d;
      resp_q     <= resp_d;
      crc_en_q   <= crc_en_d;
      idx_en_q   <= idx_en_d;
      pin_out_q  <= pin_out_d;
      pin_oe_q   <= pin_oe_d;
      response_q <= response_d;
      err_q      <= err_d;
    end
  assign cmd_pin_out     = pin_out_q;
  assign cmd_pin_oe      = pin_oe_q;
  assign bus.busy        = !(state_q inside {IDLE, FINISH});
  assign bus.done        = state_q == FINISH;
  assign bus.response    = response_q;
  assign bus.timeout_err = err_q.timeout;
  assign bus.crc_err     = err_q.crc;
  assign bus.end_bit_err = err_q.end_bit;
  assign bus.index_err   = err_q.index;
endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb_sd_cmd_phy: directed vector table plus reset/ignored-start sequences for sd_cmd_phy
module tb_sd_cmd_phy;
  localparam int M_NONE = 0, M_GOOD = 1, M_SILENT = 2, M_CRC = 3, M_END = 4;
  localparam logic [119:0] P136 = 120'h0123456789ABCDEF_FEDCBA98765432;
  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    logic         crc_en;
    logic         idx_en;
    int           div;
    int           mode;
    logic [5:0]   rep_idx;
    logic [119:0] payload;
    logic [47:0]  frame;
    logic [127:0] resp;
    logic [3:0]   errs;
  } vec_t;
  logic clock, reset, sd_clk_en, cmd_pin_in, cmd_pin_out, cmd_pin_oe;
  int tests, fails;
  vec_t vecs[11];
  sd_cmd_phy_if bus();
  sd_cmd_phy dut (
    .clock(clock), .reset(reset), .sd_clk_en(sd_clk_en), .cmd_pin_in(cmd_pin_in),
    .cmd_pin_out(cmd_pin_out), .cmd_pin_oe(cmd_pin_oe), .bus(bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
    logic [6:0] c = 7'h00;
    logic fb;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic sd_tick(input logic pin, input int div);
    sd_clk_en = 1'b0;
    repeat (div - 1) tick();
    cmd_pin_in = pin;
    sd_clk_en  = 1'b1;
    tick();
    sd_clk_en = 1'b0;
  endtask
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt, input logic ce, input logic ie);
    bus.cmd_index      = idx;
    bus.cmd_argument   = arg;
    bus.resp_type      = rt;
    bus.crc_check_en   = ce;
    bus.index_check_en = ie;
    bus.start          = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic run_tx(input int div, output logic [47:0] frame, output logic oe_ok);
    frame = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      sd_tick(1'b1, div);
      frame = {frame[46:0], cmd_pin_out};
      oe_ok &= cmd_pin_oe;
    end
  endtask
  function automatic logic [3:0] errs_now();
    return {bus.timeout_err, bus.crc_err, bus.end_bit_err, bus.index_err};
  endfunction
  initial begin
    logic [47:0]  frame;
    logic         oe_ok, saw_done;
    logic [39:0]  body;
    logic [135:0] rep;
    logic [6:0]   c;
    int           rlen;
    vec_t         v;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    sd_clk_en = 1'b0;
    cmd_pin_in = 1'b1;
    bus.start = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_argument = '0;
    bus.resp_type = '0;
    bus.crc_check_en = 1'b0;
    bus.index_check_en = 1'b0;
    vecs[0]  = '{6'd0,  32'h0,        2'b00, 1'b1, 1'b1, 2, M_NONE,   6'd0,  120'h0,        48'h400000000095, 128'h0,        4'b0000};
    vecs[1]  = '{6'd8,  32'h000001AA, 2'b10, 1'b1, 1'b1, 1, M_GOOD,   6'd8,  120'h1AA,      48'h48000001AA87, 128'h1AA,      4'b0000};
    vecs[2]  = '{6'd8,  32'h000001AA, 2'b10, 1'b1, 1'b1, 1, M_SILENT, 6'd8,  120'h0,        48'h48000001AA87, 128'h0,        4'b1000};
    vecs[3]  = '{6'd55, 32'h0,        2'b10, 1'b1, 1'b1, 3, M_GOOD,   6'd55, 120'h120,      48'h770000000065, 128'h120,      4'b0000};
    vecs[4]  = '{6'd41, 32'h40000000, 2'b11, 1'b0, 1'b0, 1, M_CRC,    6'd63, 120'h80FF8000, 48'h694000000077, 128'h80FF8000, 4'b0000};
    vecs[5]  = '{6'd2,  32'h0,        2'b01, 1'b1, 1'b1, 1, M_GOOD,   6'd0,  P136,          48'h42000000004D, {8'h00, P136}, 4'b0000};
    vecs[6]  = '{6'd2,  32'h0,        2'b01, 1'b1, 1'b1, 1, M_CRC,    6'd0,  P136,          48'h42000000004D, {8'h00, P136}, 4'b0100};
    vecs[7]  = '{6'd2,  32'h0,        2'b01, 1'b1, 1'b1, 2, M_END,    6'd0,  P136,          48'h42000000004D, {8'h00, P136}, 4'b0010};
    vecs[8]  = '{6'd8,  32'h000001AA, 2'b10, 1'b1, 1'b1, 1, M_GOOD,   6'd3,  120'h1AA,      48'h48000001AA87, 128'h1AA,      4'b0001};
    vecs[9]  = '{6'd8,  32'h000001AA, 2'b10, 1'b1, 1'b0, 1, M_GOOD,   6'd3,  120'h1AA,      48'h48000001AA87, 128'h1AA,      4'b0000};
    vecs[10] = '{6'd8,  32'h000001AA, 2'b11, 1'b1, 1'b1, 2, M_END,    6'd8,  120'h1AA,      48'h48000001AA87, 128'h1AA,      4'b0010};
    repeat (3) tick();
    chk("rst_oe", cmd_pin_oe, 0);
    chk("rst_out", cmd_pin_out, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_resp", bus.response, 0);
    chk("rst_errs", errs_now(), 0);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 11; k++) begin
      v = vecs[k];
      issue(v.idx, v.arg, v.rt, v.crc_en, v.idx_en);
      chk($sformatf("v%0d_busy_start", k), bus.busy, 1);
      chk($sformatf("v%0d_cleared", k), {errs_now(), bus.response}, 0);
      run_tx(v.div, frame, oe_ok);
      chk($sformatf("v%0d_frame", k), frame, v.frame);
      chk($sformatf("v%0d_oe_send", k), oe_ok, 1);
      if (v.mode == M_SILENT) begin
        repeat (63) sd_tick(1'b1, v.div);
        chk($sformatf("v%0d_no_early_to", k), {bus.done, bus.busy}, 2'b01);
        sd_tick(1'b1, v.div);
      end else if (v.mode != M_NONE) begin
        if (v.rt == 2'b01) begin
          c    = crc7(v.payload, 120) ^ (v.mode == M_CRC ? 7'h01 : 7'h00);
          rep  = {8'h3F, v.payload, c, v.mode != M_END};
          rlen = 136;
        end else begin
          body = {2'b00, v.rep_idx, v.payload[31:0]};
          c    = crc7({80'h0, body}, 40) ^ (v.mode == M_CRC ? 7'h01 : 7'h00);
          rep  = {body, c, v.mode != M_END, 88'h0};
          rlen = 48;
        end
        sd_tick(1'b1, v.div);
        chk($sformatf("v%0d_release", k), {cmd_pin_oe, cmd_pin_out}, 2'b01);
        sd_tick(1'b1, v.div);
        for (int i = 0; i < rlen; i++) sd_tick(rep[135 - i], v.div);
      end
      chk($sformatf("v%0d_done", k), {bus.done, bus.busy}, 2'b10);
      chk($sformatf("v%0d_errs", k), errs_now(), v.errs);
      chk($sformatf("v%0d_resp", k), bus.response, v.resp);
      cmd_pin_in = 1'b1;
      tick();
      chk($sformatf("v%0d_done_pulse", k), {bus.done, bus.busy}, 2'b00);
    end
    issue(6'd8, 32'h000001AA, 2'b10, 1'b1, 1'b1);
    repeat (10) sd_tick(1'b1, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_pins", {cmd_pin_oe, cmd_pin_out}, 2'b01);
    chk("midrst_busy_done", {bus.busy, bus.done}, 2'b00);
    chk("midrst_resp", bus.response, 0);
    saw_done = 1'b0;
    sd_clk_en = 1'b1;
    repeat (60) begin
      tick();
      saw_done |= bus.done | bus.busy;
    end
    sd_clk_en = 1'b0;
    chk("midrst_quiet", saw_done, 0);
    issue(6'd0, 32'h0, 2'b00, 1'b0, 1'b0);
    frame = '0;
    for (int i = 0; i < 48; i++) begin
      if (i == 5) begin
        bus.cmd_index = 6'd8;
        bus.start     = 1'b1;
      end
      sd_tick(1'b1, 1);
      bus.start = 1'b0;
      frame = {frame[46:0], cmd_pin_out};
    end
    chk("restart_frame", frame, 48'h400000000095);
    chk("restart_done", bus.done, 1);
    saw_done = 1'b0;
    repeat (6) begin
      tick();
      saw_done |= bus.busy | bus.done;
    end
    chk("no_queued_start", saw_done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
- Command-line physical layer between the command sequencer and the SD CMD pin.
- Serialises a 48-bit command frame (start, transmission, index, argument, CRC7, end) and receives the 48- or 136-bit response.
- Checks the response (timeout, CRC, end bit, index) and presents the result with a one-cycle done pulse for the sequencer and the response/interrupt registers.
- Single clock domain; SD bit timing comes from a clock-enable strobe.

Parameters:
TIMEOUT_TICKS, 64, SD-clock ticks allowed from command end bit to response start bit (NCR)
NCC_TICKS, 8, idle SD-clock ticks enforced after a transaction (used only with CMD_NCC_GAP_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
sd_clk_en  in  1  one-cycle strobe per SD clock rising edge; all bit activity advances only on it
start  in  1  one-cycle command request; ignored unless idle
cmd_index  in  6  command index
cmd_argument  in  32  command argument
resp_type  in  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit busy (treated as 48-bit)
crc_check_en  in  1  enable response CRC check
index_check_en  in  1  enable response index check
cmd_pin_in  in  1  sampled CMD line
cmd_pin_out  out  1  driven CMD value
cmd_pin_oe  out  1  CMD output enable
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
response  out  128  captured response
timeout_err  out  1  valid with done
crc_err  out  1  valid with done
end_bit_err  out  1  valid with done
index_err  out  1  valid with done

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, cmd_pin_out=1, cmd_pin_oe=0, busy=0, done=0, all error flags=0, response=0. Applies mid-transaction too; an in-flight frame is abandoned with no done pulse.
- FSM states: IDLE, SEND, WAIT_RESP, RECV, FINISH (plus GAP with the option).
- IDLE:
  - On start, latch cmd_index, cmd_argument, resp_type and both check enables.
  - busy=1 from the next cycle; clear the error flags.
  - Go to SEND.
- SEND:
  - On each sd_clk_en, drive one bit MSB-first with cmd_pin_oe=1: bit47=0, bit46=1, [45:40]=index, [39:8]=argument, [7:1]=CRC7, bit0=1.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, over bits 47..8, computed serially while shifting.
  - The first bit is driven on the first sd_clk_en after start. Exactly 48 strobes are consumed.
  - After the end bit's strobe: go to FINISH if resp_type==00, else go to WAIT_RESP with cmd_pin_oe=0 and cmd_pin_out=1.
- WAIT_RESP:
  - On each strobe, sample cmd_pin_in. A 0 means start bit seen: go to RECV with bit counter = 1.
  - Otherwise increment the tick counter. When it reaches TIMEOUT_TICKS, set timeout_err and go to FINISH.
- RECV:
  - Shift one bit per strobe until 48 (or 136) bits have been received, including the start bit.
  - CRC7 covers bits 47..8 for 48-bit responses and bits 127..8 for 136-bit responses (the leading 8 bits are excluded).
- Checks on the last bit:
  - end_bit_err if the last bit is 0.
  - crc_err if crc_check_en and the computed CRC differs from the received CRC.
  - index_err if index_check_en, the response is 48-bit, and received [45:40] differs from cmd_index.
- Response mapping:
  - 48-bit: response[31:0] = bits[39:8], upper bits 0.
  - 136-bit: response[119:0] = bits[127:8], [127:120] = 0.
- FINISH: done=1 for exactly one cycle; busy falls in the same cycle; return to IDLE. Error flags and response hold until the next start.
- A start pulse while busy is ignored, with no queueing.
- An sd_clk_en held high continuously is legal and gives one bit per clock.

Optional Feature:
CMD_NCC_GAP_EN:
- Defined: FINISH goes to GAP. busy stays high for NCC_TICKS strobes with cmd_pin_out=1 and cmd_pin_oe=0, then returns to IDLE. done still pulses in FINISH.
- Undefined: no GAP state; start is accepted in the cycle after done.

Decomposition:
- Shared package sd_cmd_pkg:
  - resp_type encodings
  - FSM state enum
  - CRC7 polynomial constant
  - frame widths 48/136
- Sub-module sd_crc7: serial CRC7 with clear, enable and data-bit inputs, and a 7-bit output. It is instantiated twice, once for TX and once for RX.

Test Plan:
- CMD0: index 0, arg 0, resp_type 00 → pin sequence 0x400000000095 MSB-first over 48 strobes; done one cycle after the final strobe; no errors.
- CMD8: arg 0x000001AA, resp_type 10 → TX frame 0x48000001AA87. Card model returns a model-CRC R7 echo → response = 0x000001AA, no errors.
- Same as previous with cmd_pin_in held high → timeout_err=1 after exactly 64 strobes; done pulses; response = 0.
- 136-bit response with one flipped CRC bit and crc_check_en=1 → crc_err=1 and response[119:0] still captured. Same response with end bit 0 → end_bit_err=1.
- Response index mismatch (reply index 3 to CMD8) → index_err=1 with index_check_en=1, 0 with index_check_en=0.
- Reset asserted mid-SEND → next cycle: cmd_pin_oe=0, cmd_pin_out=1, busy=0, no done pulse. A new start afterwards sends a full frame.
